// File: rtl/gaplus_boot_ctrl.sv
// Boot/reset sequencer for FPGA_GAPLUS: holds the OSD request after power-on,
// gates data_io ROM writes into the core, and holds core reset until a complete image has settled.
module gaplus_boot_ctrl #(
    parameter int POR_CYCLES    = 65535,
    parameter int SETTLE_CYCLES = 1024,
    parameter int ADDR_W        = 18,
    parameter int EXPECT_BYTES  = 196608
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              user_reset,
    output logic              core_reset,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              osd_req,
    output logic              rom_ok,
    output logic              rom_err,
    output logic              led_n
);

    localparam logic [2:0] ST_POR    = 3'd0;
    localparam logic [2:0] ST_NOROM  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_RUN    = 3'd4;

    localparam int PW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BW = $clog2(EXPECT_BYTES + 1);

    localparam logic [PW-1:0]   POR_LAST    = PW'(POR_CYCLES - 1);
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0]   BYTES_FULL  = BW'(EXPECT_BYTES);
    localparam logic [ADDR_W:0] ADDR_LIM    = (ADDR_W + 1)'(EXPECT_BYTES);

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [PW-1:0]     por_cnt_r;
    logic [SW-1:0]     settle_cnt_r;
    logic [BW-1:0]     byte_cnt_r;
    logic [BW-1:0]     byte_base_s;
    logic [BW-1:0]     byte_cnt_s;
    logic              accept_s;
    logic              load_entry_s;
    logic              load_done_s;
    logic              core_reset_r;
    logic              rom_we_r;
    logic [ADDR_W-1:0] rom_addr_r;
    logic [7:0]        rom_data_r;
    logic              osd_req_r;
    logic              rom_ok_r;
    logic              rom_err_r;
    logic              led_n_r;

    // Write acceptance and byte counting; the last LOAD cycle accepts a strobe that coincides with download falling.
    always_comb begin
        accept_s     = ioctl_wr && ({1'b0, ioctl_addr} < ADDR_LIM) &&
                       (ioctl_download || (state_r == ST_LOAD));
        load_entry_s = ioctl_download && (state_r != ST_LOAD);
        load_done_s  = (state_r == ST_LOAD) && !ioctl_download;
        if (load_entry_s) begin
            byte_base_s = '0;
        end else begin
            byte_base_s = byte_cnt_r;
        end
        if (accept_s && (byte_base_s != BYTES_FULL)) begin
            byte_cnt_s = byte_base_s + 1'b1;
        end else begin
            byte_cnt_s = byte_base_s;
        end
    end

    // Next-state selection; a download request always wins.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_POR: begin
                if (ioctl_download) begin
                    state_s = ST_LOAD;
                end else if (por_cnt_r == POR_LAST) begin
                    state_s = ST_NOROM;
                end else begin
                    state_s = ST_POR;
                end
            end
            ST_NOROM: begin
                if (ioctl_download) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_NOROM;
                end
            end
            ST_LOAD: begin
                if (ioctl_download) begin
                    state_s = ST_LOAD;
                end else if (byte_cnt_s == BYTES_FULL) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_NOROM;
                end
            end
            ST_SETTLE: begin
                if (ioctl_download) begin
                    state_s = ST_LOAD;
                end else if (!user_reset && (settle_cnt_r == SETTLE_LAST)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (ioctl_download) begin
                    state_s = ST_LOAD;
                end else if (user_reset) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_POR;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r      <= ST_POR;
            por_cnt_r    <= '0;
            settle_cnt_r <= '0;
            byte_cnt_r   <= '0;
            core_reset_r <= 1'b1;
            rom_we_r     <= 1'b0;
            rom_addr_r   <= '0;
            rom_data_r   <= 8'h00;
            osd_req_r    <= 1'b0;
            rom_ok_r     <= 1'b0;
            rom_err_r    <= 1'b0;
            led_n_r      <= 1'b1;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            // The POR count only advances once the request is visible, so it is held for POR_CYCLES clocks.
            if ((state_r == ST_POR) && osd_req_r && (por_cnt_r != POR_LAST)) begin
                por_cnt_r <= por_cnt_r + 1'b1;
            end else begin
                por_cnt_r <= por_cnt_r;
            end
            if ((state_r == ST_SETTLE) && (state_s == ST_SETTLE) && !user_reset) begin
                settle_cnt_r <= settle_cnt_r + 1'b1;
            end else begin
                settle_cnt_r <= '0;
            end
            // Rises with the decision to leave RUN, falls one clock after RUN is reached.
            core_reset_r <= (state_s != ST_RUN) || (state_r != ST_RUN);
            rom_we_r     <= accept_s;
            if (accept_s) begin
                rom_addr_r <= ioctl_addr;
                rom_data_r <= ioctl_dout;
            end else begin
                rom_addr_r <= rom_addr_r;
                rom_data_r <= rom_data_r;
            end
            osd_req_r <= (state_s == ST_POR);
            led_n_r   <= (state_s != ST_LOAD);
            if (load_entry_s) begin
                rom_ok_r  <= 1'b0;
                rom_err_r <= 1'b0;
            end else if (load_done_s) begin
                rom_ok_r  <= (byte_cnt_s == BYTES_FULL);
                rom_err_r <= (byte_cnt_s != BYTES_FULL);
            end else begin
                rom_ok_r  <= rom_ok_r;
                rom_err_r <= rom_err_r;
            end
        end
    end

    assign core_reset = core_reset_r;
    assign rom_we     = rom_we_r;
    assign rom_addr   = rom_addr_r;
    assign rom_data   = rom_data_r;
    assign osd_req    = osd_req_r;
    assign rom_ok     = rom_ok_r;
    assign rom_err    = rom_err_r;
    assign led_n      = led_n_r;

endmodule

// File: tb/tb_gaplus_boot_ctrl.sv
// Bench for gaplus_boot_ctrl: directed and randomized download/user-reset sequences
// compared every clock against an event-time reference model.
module tb_gaplus_boot_ctrl;

    localparam int POR_C = 16;
    localparam int SET_C = 4;
    localparam int AW    = 6;
    localparam int EXP   = 8;

    localparam int M_POR    = 0;
    localparam int M_NOROM  = 1;
    localparam int M_LOAD   = 2;
    localparam int M_SETTLE = 3;
    localparam int M_RUN    = 4;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_dout = 8'h00;
    logic          user_reset = 1'b0;
    logic          core_reset;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          osd_req;
    logic          rom_ok;
    logic          rom_err;
    logic          led_n;

    gaplus_boot_ctrl #(
        .POR_CYCLES(POR_C), .SETTLE_CYCLES(SET_C), .ADDR_W(AW), .EXPECT_BYTES(EXP)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .user_reset(user_reset), .core_reset(core_reset), .rom_we(rom_we),
        .rom_addr(rom_addr), .rom_data(rom_data), .osd_req(osd_req),
        .rom_ok(rom_ok), .rom_err(rom_err), .led_n(led_n)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode plus absolute edge times of the relevant events.
    int            m_mode, m_cyc, m_por_edges, m_settle_start, m_run_since, m_nbytes;
    logic          e_core, e_we, e_osd, e_ok, e_err, e_led;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_data;

    function automatic void model_reset();
        m_mode = M_POR; m_cyc = 0; m_por_edges = 0;
        m_settle_start = 0; m_run_since = 0; m_nbytes = 0;
        e_core = 1'b1; e_we = 1'b0; e_addr = '0; e_data = 8'h00;
        e_osd = 1'b0; e_ok = 1'b0; e_err = 1'b0; e_led = 1'b1;
    endfunction

    function automatic void enter_load();
        m_mode = M_LOAD; m_nbytes = 0; e_ok = 1'b0; e_err = 1'b0;
    endfunction

    function automatic void model_step(input logic dl, input logic wr, input logic [AW-1:0] a,
                                       input logic [7:0] d, input logic ur);
        int  orig;
        bit  acc;
        orig = m_mode;
        acc  = wr && (int'(a) < EXP) && (dl || (orig == M_LOAD));
        m_cyc++;
        case (orig)
            M_POR: begin
                m_por_edges++;
                if (dl) enter_load();
                else if (m_por_edges > POR_C) m_mode = M_NOROM;
            end
            M_NOROM: if (dl) enter_load();
            M_SETTLE: begin
                if (dl) enter_load();
                else if (ur) m_settle_start = m_cyc;
                else if (m_cyc - m_settle_start >= SET_C) begin
                    m_mode = M_RUN; m_run_since = m_cyc;
                end
            end
            M_RUN: begin
                if (dl) enter_load();
                else if (ur) begin m_mode = M_SETTLE; m_settle_start = m_cyc; end
            end
            default: ;
        endcase
        e_we = acc;
        if (acc) begin
            if (m_nbytes < EXP) m_nbytes++;
            e_addr = a; e_data = d;
        end
        if (orig == M_LOAD && !dl) begin
            if (m_nbytes == EXP) begin
                m_mode = M_SETTLE; m_settle_start = m_cyc; e_ok = 1'b1;
            end else begin
                m_mode = M_NOROM; e_err = 1'b1;
            end
        end
        e_osd  = (m_mode == M_POR);
        e_led  = (m_mode != M_LOAD);
        e_core = !(m_mode == M_RUN && m_cyc > m_run_since);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s at t=%0t: observed %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("core_reset", 32'(core_reset), 32'(e_core));
        chk("rom_we",     32'(rom_we),     32'(e_we));
        chk("rom_addr",   32'(rom_addr),   32'(e_addr));
        chk("rom_data",   32'(rom_data),   32'(e_data));
        chk("osd_req",    32'(osd_req),    32'(e_osd));
        chk("rom_ok",     32'(rom_ok),     32'(e_ok));
        chk("rom_err",    32'(rom_err),    32'(e_err));
        chk("led_n",      32'(led_n),      32'(e_led));
    endtask

    task automatic tick(input logic dl, input logic wr, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic ur);
        ioctl_download = dl; ioctl_wr = wr; ioctl_addr = a; ioctl_dout = d; user_reset = ur;
        @(posedge clk_sys);
        model_step(dl, wr, a, d, ur);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input logic ur);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 8'h00, ur);
    endtask

    // One download: nb strobes (random gaps), optional out-of-range strobe, optional strobe on the falling cycle.
    task automatic load_image(input int nb, input bit oob, input bit coinc, input bit ur_first,
                              input bit rnd);
        logic [AW-1:0] a;
        logic [7:0]    d;
        tick(1'b1, 1'b0, '0, 8'h00, ur_first);
        for (int i = 0; i < nb; i++) begin
            a = rnd ? AW'($urandom_range(0, EXP - 1)) : AW'(i);
            d = rnd ? 8'($urandom) : 8'(8'hA0 + i);
            if (rnd) for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick(1'b1, 1'b0, '0, 8'h00, 1'b0);
            if (oob && i == nb / 2) tick(1'b1, 1'b1, AW'(EXP + 1), 8'h5A, 1'b0);
            if (coinc && i == nb - 1) begin
                tick(1'b0, 1'b1, a, d, 1'b0);
                return;
            end
            tick(1'b1, 1'b1, a, d, 1'b0);
        end
        if (oob && nb == 0) tick(1'b1, 1'b1, AW'(EXP + 1), 8'h5A, 1'b0);
        tick(1'b1, 1'b0, '0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, '0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        check_all();
        @(posedge clk_sys);
        #1;
        check_all();
        ioctl_download = 1'b0; ioctl_wr = 1'b0; user_reset = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check_all();
        reset = 1'b0;

        // Power-on with no download: OSD request window, then NOROM holding core reset.
        idle(POR_C + 1000, 1'b0);

        // Full image with download rising on the fifth cycle after reset release.
        do_reset();
        idle(4, 1'b0);
        load_image(EXP, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8, 1'b0);

        // User reset pulse in RUN, then user reset held across SETTLE.
        tick(1'b0, 1'b0, '0, 8'h00, 1'b1);
        idle(8, 1'b0);
        tick(1'b0, 1'b0, '0, 8'h00, 1'b1);
        idle(3, 1'b1);
        idle(8, 1'b0);

        // Reload from RUN with user reset rising together with download.
        load_image(EXP, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(8, 1'b0);

        // Short image plus one out-of-range strobe, then strobes without download and user reset in NOROM.
        load_image(6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, AW'(3), 8'h33, 1'b0);
        idle(4, 1'b1);
        idle(4, 1'b0);

        // Last strobe coincident with download falling; then a download abandoning SETTLE.
        load_image(EXP, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        load_image(EXP + 2, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(8, 1'b0);

        // Randomized sequences.
        for (int it = 0; it < 40; it++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0: load_image(int'($urandom_range(EXP - 1, EXP + 3)), 1'($urandom), 1'($urandom),
                              1'($urandom), 1'b1);
                1: begin tick(1'b0, 1'b0, '0, 8'h00, 1'b1); idle(int'($urandom_range(1, 7)), 1'b0); end
                2: for (int k = 0; k < int'($urandom_range(1, 10)); k++)
                       tick(1'b0, 1'($urandom), AW'($urandom), 8'($urandom), 1'b0);
                3: begin idle(int'($urandom_range(1, 5)), 1'b1); idle(int'($urandom_range(1, 7)), 1'b0); end
                default: load_image(int'($urandom_range(0, EXP - 1)), 1'($urandom), 1'b0, 1'b0, 1'b1);
            endcase
        end
        idle(8, 1'b0);

        // Asynchronous reset in the middle of a download after three bytes.
        tick(1'b1, 1'b0, '0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, AW'(i), 8'(8'hC0 + i), 1'b0);
        do_reset();
        idle(3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
